// File: rtl/selectio_align_pkg.sv
// Shared types, default constants and width helpers for the select_io word-alignment controller.
package selectio_align_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SRST,
    ST_WAIT_RDY,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } align_state_e;

  localparam int         DEF_DW        = 4;
  localparam int         DEF_SP_MULT   = 4;
  localparam logic [3:0] DEF_TRAIN_PAT = 4'b1100;
  localparam int         DEF_MATCH_CNT = 16;
  localparam int         DEF_SLIP_WAIT = 8;
  localparam int         DEF_RST_CYC   = 4;
  localparam int         DEF_MAX_SLIP  = 8;

  // Lane index needs at least one bit even for a single-lane build.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/selectio_match_cnt.sv
// Saturating consecutive-event counter: counts cycles where word==pattern (or word!=pattern when
// COUNT_MISS=1) and flags the cycle on which the run reaches THRESH.
module selectio_match_cnt #(
  parameter int W          = 4,
  parameter int THRESH     = 16,
  parameter bit COUNT_MISS = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_word,
  input  logic [W-1:0] i_pattern,
  output logic         o_hit,
  output logic         o_miss
);

  localparam int CW = $clog2(THRESH + 1);

  logic [CW-1:0] r_cnt;
  logic          w_eq;
  logic          w_event;

  assign w_eq    = (i_word == i_pattern);
  assign w_event = COUNT_MISS ? !w_eq : w_eq;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_en) begin
      r_cnt <= '0;
    end else if (w_event) begin
      if (r_cnt != CW'(THRESH)) r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Hit fires on the cycle that completes the run, so the caller can act without an extra cycle.
  assign o_hit  = i_en && w_event && (r_cnt >= CW'(THRESH - 1));
  assign o_miss = i_en && !w_eq;

endmodule

// File: rtl/selectio_align_ctrl.sv
// Word-alignment training FSM for the select_io ISERDES lanes: SerDes reset, IDELAYCTRL wait,
// then per-lane bitslip until TRAIN_PAT holds. Optional lock monitor: SELECTIO_ALIGN_MONITOR_EN.
module selectio_align_ctrl
  import selectio_align_pkg::*;
#(
  parameter int                 DW        = DEF_DW,
  parameter int                 SP_Mult   = DEF_SP_MULT,
  parameter logic [SP_Mult-1:0] TRAIN_PAT = SP_Mult'(DEF_TRAIN_PAT),
  parameter int                 MATCH_CNT = DEF_MATCH_CNT,
  parameter int                 SLIP_WAIT = DEF_SLIP_WAIT,
  parameter int                 RST_CYC   = DEF_RST_CYC,
  parameter int                 MAX_SLIP  = DEF_MAX_SLIP
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_dly_rdy,
  input  logic [DW*SP_Mult-1:0]   i_pardata,
  output logic                    o_serdes_rst,
  output logic [DW-1:0]           o_bitslip,
  output logic                    o_busy,
  output logic                    o_locked,
  output logic                    o_fail,
  output logic [DW-1:0]           o_lane_ok,
  output logic [lane_w(DW)-1:0]   o_fail_lane
`ifdef SELECTIO_ALIGN_MONITOR_EN
  ,
  output logic [7:0]              o_relock_cnt
`endif
);

  localparam int LW = lane_w(DW);
  localparam int MW = cnt_w(MAX_SLIP);
  localparam int WW = cnt_w(SLIP_WAIT);
  localparam int RW = cnt_w(RST_CYC);

  align_state_e  r_state;
  logic [LW-1:0] r_lane;
  logic [MW-1:0] r_slip_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [RW-1:0] r_rst_cnt;
  logic          r_serdes_rst;
  logic [DW-1:0] r_bitslip;
  logic          r_busy;
  logic          r_locked;
  logic          r_fail;
  logic [DW-1:0] r_lane_ok;
  logic [LW-1:0] r_fail_lane;

  logic [SP_Mult-1:0] w_lane_word;
  logic [DW-1:0]      w_lane_onehot;
  logic               w_hit;
  logic               w_miss;
  logic               w_mon_trip;
  logic               w_restart;

  always_comb begin
    w_lane_word = '0;
    for (int l = 0; l < DW; l++) begin
      if (r_lane == LW'(l)) w_lane_word = i_pardata[l*SP_Mult +: SP_Mult];
    end
  end

  assign w_lane_onehot = DW'(1) << r_lane;

  selectio_match_cnt #(
    .W          (SP_Mult),
    .THRESH     (MATCH_CNT),
    .COUNT_MISS (1'b0)
  ) u_match (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (r_state == ST_CHECK),
    .i_clr     (r_state == ST_NEXT),
    .i_word    (w_lane_word),
    .i_pattern (TRAIN_PAT),
    .o_hit     (w_hit),
    .o_miss    (w_miss)
  );

`ifdef SELECTIO_ALIGN_MONITOR_EN
  logic [DW-1:0] w_mon_hit;
  logic [DW-1:0] w_mon_miss;
  logic [7:0]    r_relock_cnt;

  for (genvar l = 0; l < DW; l++) begin : g_mon
    selectio_match_cnt #(
      .W          (SP_Mult),
      .THRESH     (MATCH_CNT),
      .COUNT_MISS (1'b1)
    ) u_mon (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (r_state == ST_DONE),
      .i_clr     (1'b0),
      .i_word    (i_pardata[l*SP_Mult +: SP_Mult]),
      .i_pattern (TRAIN_PAT),
      .o_hit     (w_mon_hit[l]),
      .o_miss    (w_mon_miss[l])
    );
  end

  assign w_mon_trip = |(w_mon_hit & w_mon_miss);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_relock_cnt <= '0;
    end else if (w_mon_trip && (r_relock_cnt != 8'hFF)) begin
      r_relock_cnt <= r_relock_cnt + 8'd1;
    end
  end

  assign o_relock_cnt = r_relock_cnt;
`else
  assign w_mon_trip = 1'b0;
`endif

  // i_start is a one-cycle request accepted only while idle (IDLE/DONE/FAIL); while busy it is dropped.
  assign w_restart = w_mon_trip ||
                     (i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_lane       <= '0;
      r_slip_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_rst_cnt    <= '0;
      r_serdes_rst <= 1'b0;
      r_bitslip    <= '0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_lane_ok    <= '0;
      r_fail_lane  <= '0;
    end else begin
      r_bitslip <= '0;
      if (w_restart) begin
        r_state      <= ST_SRST;
        r_lane       <= '0;
        r_slip_cnt   <= '0;
        r_wait_cnt   <= '0;
        r_rst_cnt    <= '0;
        r_serdes_rst <= 1'b1;
        r_busy       <= 1'b1;
        r_locked     <= 1'b0;
        r_fail       <= 1'b0;
        r_lane_ok    <= '0;
      end else begin
        case (r_state)
          ST_SRST: begin
            if (r_rst_cnt == RW'(RST_CYC - 1)) begin
              r_serdes_rst <= 1'b0;
              r_state      <= ST_WAIT_RDY;
            end else begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
          ST_WAIT_RDY: begin
            if (i_dly_rdy) r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (w_hit) begin
              r_lane_ok[r_lane] <= 1'b1;
              r_state           <= ST_NEXT;
            end else if (w_miss) begin
              r_state <= ST_SLIP;
              // Pulse is launched here so it is visible exactly during the SLIP cycle.
              if (r_slip_cnt != MW'(MAX_SLIP)) r_bitslip <= w_lane_onehot;
            end
          end
          ST_SLIP: begin
            if (r_slip_cnt == MW'(MAX_SLIP)) begin
              r_state     <= ST_FAIL;
              r_fail      <= 1'b1;
              r_busy      <= 1'b0;
              r_fail_lane <= r_lane;
            end else begin
              r_slip_cnt <= r_slip_cnt + 1'b1;
              r_wait_cnt <= '0;
              r_state    <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (r_wait_cnt == WW'(SLIP_WAIT - 1)) r_state <= ST_CHECK;
            else r_wait_cnt <= r_wait_cnt + 1'b1;
          end
          ST_NEXT: begin
            r_slip_cnt <= '0;
            if (r_lane == LW'(DW - 1)) begin
              r_state  <= ST_DONE;
              r_locked <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_lane  <= r_lane + 1'b1;
              r_state <= ST_CHECK;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_serdes_rst = r_serdes_rst;
  assign o_bitslip    = r_bitslip;
  assign o_busy       = r_busy;
  assign o_locked     = r_locked;
  assign o_fail       = r_fail;
  assign o_lane_ok    = r_lane_ok;
  assign o_fail_lane  = r_fail_lane;

endmodule

// File: tb/tb_selectio_align_ctrl.sv
// Directed bench for selectio_align_ctrl with a rotating-lane bitslip model; monitor scenario
// runs when SELECTIO_ALIGN_MONITOR_EN is defined.
module tb_selectio_align_ctrl;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic        i_dly_rdy;
  logic [15:0] i_pardata;
  logic        o_serdes_rst;
  logic [3:0]  o_bitslip;
  logic        o_busy;
  logic        o_locked;
  logic        o_fail;
  logic [3:0]  o_lane_ok;
  logic [1:0]  o_fail_lane;
`ifdef SELECTIO_ALIGN_MONITOR_EN
  logic [7:0]  o_relock_cnt;
`endif

  logic [3:0] lane_word [4];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int slips [4];
  int last_slip_cyc;
  int min_gap;
  int multi_hot;

  assign i_pardata = {lane_word[3], lane_word[2], lane_word[1], lane_word[0]};

  selectio_align_ctrl dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_dly_rdy    (i_dly_rdy),
    .i_pardata    (i_pardata),
    .o_serdes_rst (o_serdes_rst),
    .o_bitslip    (o_bitslip),
    .o_busy       (o_busy),
    .o_locked     (o_locked),
    .o_fail       (o_fail),
    .o_lane_ok    (o_lane_ok),
    .o_fail_lane  (o_fail_lane)
`ifdef SELECTIO_ALIGN_MONITOR_EN
    ,
    .o_relock_cnt (o_relock_cnt)
`endif
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Lane model: each bitslip rotates the lane word right by one bit.
  always @(negedge clk) begin
    cyc++;
    if (o_bitslip != 4'b0000) begin
      if ($countones(o_bitslip) != 1) multi_hot++;
      for (int l = 0; l < 4; l++) begin
        if (o_bitslip[l]) begin
          slips[l]++;
          if (last_slip_cyc >= 0 && (cyc - last_slip_cyc) < min_gap) min_gap = cyc - last_slip_cyc;
          last_slip_cyc = cyc;
          lane_word[l] = {lane_word[l][0], lane_word[l][3:1]};
        end
      end
    end
  end

  task automatic clr_stats();
    for (int l = 0; l < 4; l++) slips[l] = 0;
    last_slip_cyc = -1;
    min_gap       = 1000000;
    multi_hot     = 0;
  endtask

  task automatic set_lanes(input logic [3:0] w0, input logic [3:0] w1,
                           input logic [3:0] w2, input logic [3:0] w3);
    lane_word[0] = w0;
    lane_word[1] = w1;
    lane_word[2] = w2;
    lane_word[3] = w3;
  endtask

  // Driver: single-cycle start; returns at the negedge of cycle 1 after acceptance.
  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // sel: 0 = o_locked, 1 = o_fail, 2 = o_bitslip[2]. Tracks o_serdes_rst high cycles meanwhile.
  task automatic wait_until(input int sel, input int budget, inout int n, output bit ok,
                            output int rst_hi, output int rst_first, output int rst_last);
    bit cond;
    ok = 1'b0; rst_hi = 0; rst_first = -1; rst_last = -1;
    for (int k = 0; k < budget; k++) begin
      if (o_serdes_rst) begin
        rst_hi++;
        if (rst_first < 0) rst_first = n;
        rst_last = n;
      end
      cond = (sel == 0) ? o_locked : (sel == 1) ? o_fail : o_bitslip[2];
      if (cond) begin ok = 1'b1; break; end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({o_serdes_rst, o_bitslip, o_busy, o_locked, o_fail, o_lane_ok, o_fail_lane} !== 15'd0) begin
      failures++; $display("FAIL reset_in: got %b required 0", {o_serdes_rst, o_bitslip, o_busy, o_locked, o_fail, o_lane_ok, o_fail_lane});
    end
    i_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_serdes_rst !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got busy=%b rst=%b required 0/0", o_busy, o_serdes_rst);
    end
  endtask

  task automatic test_all_aligned();
    int n, hi, first, last; bit ok; bit busy1;
    clr_stats();
    set_lanes(4'b1100, 4'b1100, 4'b1100, 4'b1100);
    pulse_start();
    n = 1; busy1 = o_busy;
    wait_until(0, 300, n, ok, hi, first, last);
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL aligned_busy: got %b required 1", busy1); end
    checks++; if (!ok) begin failures++; $display("FAIL aligned_lock_timeout: got locked=0 required 1"); end
    checks++; if (n != 74) begin failures++; $display("FAIL aligned_lock_cycle: got %0d required 74", n); end
    checks++; if (hi != 4 || first != 1 || last != 4) begin
      failures++; $display("FAIL aligned_srst: got %0d cycles %0d..%0d required 4 cycles 1..4", hi, first, last);
    end
    checks++; if (o_lane_ok !== 4'hF) begin failures++; $display("FAIL aligned_lane_ok: got %h required F", o_lane_ok); end
    checks++; if ((slips[0] + slips[1] + slips[2] + slips[3]) != 0) begin
      failures++; $display("FAIL aligned_noslip: got %0d pulses required 0", slips[0] + slips[1] + slips[2] + slips[3]);
    end
    checks++; if (o_busy !== 1'b0 || o_fail !== 1'b0) begin
      failures++; $display("FAIL aligned_done_flags: got busy=%b fail=%b required 0/0", o_busy, o_fail);
    end
  endtask

  task automatic test_slip();
    int n, hi, first, last; bit ok;
    set_lanes(4'b1100, 4'b1100, 4'b0110, 4'b1100);
    clr_stats();
    pulse_start();
    n = 1;
    wait_until(0, 400, n, ok, hi, first, last);
    checks++; if (!ok || n != 104) begin failures++; $display("FAIL slip_lock_cycle: got ok=%0d cycle %0d required 1/104", ok, n); end
    checks++; if (slips[2] != 3 || slips[0] != 0 || slips[1] != 0 || slips[3] != 0) begin
      failures++; $display("FAIL slip_count: got %0d/%0d/%0d/%0d required 0/0/3/0", slips[0], slips[1], slips[2], slips[3]);
    end
    checks++; if (min_gap != 10) begin failures++; $display("FAIL slip_gap: got %0d required 10", min_gap); end
    checks++; if (multi_hot != 0) begin failures++; $display("FAIL slip_onehot: got %0d multi-hot cycles required 0", multi_hot); end
    checks++; if (o_lane_ok !== 4'hF) begin failures++; $display("FAIL slip_lane_ok: got %h required F", o_lane_ok); end
  endtask

  task automatic test_fail();
    int n, hi, first, last; bit ok;
    set_lanes(4'b1100, 4'b0000, 4'b1100, 4'b1100);
    clr_stats();
    pulse_start();
    n = 1;
    checks++; if (o_locked !== 1'b0) begin failures++; $display("FAIL fail_lock_clear: got %b required 0", o_locked); end
    wait_until(1, 400, n, ok, hi, first, last);
    checks++; if (!ok || n != 105) begin failures++; $display("FAIL fail_cycle: got ok=%0d cycle %0d required 1/105", ok, n); end
    checks++; if (o_fail_lane !== 2'd1) begin failures++; $display("FAIL fail_lane: got %0d required 1", o_fail_lane); end
    checks++; if (o_lane_ok !== 4'b0001) begin failures++; $display("FAIL fail_lane_ok: got %b required 0001", o_lane_ok); end
    checks++; if (slips[1] != 8 || slips[0] != 0) begin
      failures++; $display("FAIL fail_slips: got lane1=%0d lane0=%0d required 8/0", slips[1], slips[0]);
    end
    checks++; if (o_busy !== 1'b0 || o_locked !== 1'b0) begin
      failures++; $display("FAIL fail_flags: got busy=%b locked=%b required 0/0", o_busy, o_locked);
    end
  endtask

  task automatic test_dly_rdy();
    int n, hi, first, last, bad, rst_total; bit ok;
    set_lanes(4'b1100, 4'b1100, 4'b1100, 4'b1100);
    clr_stats();
    i_dly_rdy = 1'b0;
    pulse_start();
    n = 1; bad = 0; rst_total = 0;
    checks++; if (o_fail !== 1'b0) begin failures++; $display("FAIL rdy_fail_clear: got %b required 0", o_fail); end
    while (n <= 100) begin
      if (o_busy !== 1'b1 || o_bitslip !== 4'b0000 || o_locked !== 1'b0) bad++;
      if (o_serdes_rst) rst_total++;
      if (n == 50) i_start = 1'b1;
      if (n == 51) i_start = 1'b0;
      if (n == 100) i_dly_rdy = 1'b1;
      @(negedge clk);
      n++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rdy_hold: got %0d bad cycles required 0", bad); end
    checks++; if (rst_total != 4) begin failures++; $display("FAIL rdy_busy_start: got %0d srst cycles required 4", rst_total); end
    wait_until(0, 300, n, ok, hi, first, last);
    checks++; if (!ok || n != 169) begin failures++; $display("FAIL rdy_lock_cycle: got ok=%0d cycle %0d required 1/169", ok, n); end
    checks++; if (o_lane_ok !== 4'hF) begin failures++; $display("FAIL rdy_lane_ok: got %h required F", o_lane_ok); end
  endtask

  task automatic test_rst_in_slip();
    int n, hi, first, last; bit ok;
    set_lanes(4'b1100, 4'b1100, 4'b0110, 4'b1100);
    clr_stats();
    pulse_start();
    n = 1;
    wait_until(2, 400, n, ok, hi, first, last);
    checks++; if (!ok) begin failures++; $display("FAIL rst_slip_timeout: got no bitslip[2] required pulse"); end
    i_rst = 1'b1;
    @(negedge clk);
    checks++; if ({o_serdes_rst, o_bitslip, o_busy, o_locked, o_fail, o_lane_ok, o_fail_lane} !== 15'd0) begin
      failures++; $display("FAIL rst_slip_outputs: got %b required 0", {o_serdes_rst, o_bitslip, o_busy, o_locked, o_fail, o_lane_ok, o_fail_lane});
    end
    i_rst = 1'b0;
    set_lanes(4'b1100, 4'b1100, 4'b1100, 4'b1100);
    clr_stats();
    repeat (3) @(negedge clk);
    checks++; if (o_busy !== 1'b0 || o_bitslip !== 4'b0000) begin
      failures++; $display("FAIL rst_slip_idle: got busy=%b bitslip=%b required 0/0000", o_busy, o_bitslip);
    end
    pulse_start();
    n = 1;
    wait_until(0, 300, n, ok, hi, first, last);
    checks++; if (!ok || n != 74 || first != 1 || hi != 4) begin
      failures++; $display("FAIL rst_slip_retrain: got ok=%0d lock=%0d srst_first=%0d srst=%0d required 1/74/1/4", ok, n, first, hi);
    end
  endtask

`ifdef SELECTIO_ALIGN_MONITOR_EN
  task automatic test_monitor();
    int n, hi, first, last; bit ok;
    checks++; if (o_relock_cnt !== 8'd0) begin failures++; $display("FAIL mon_cnt_init: got %0d required 0", o_relock_cnt); end
    @(negedge clk);
    lane_word[3] = 4'b0011;
    repeat (15) @(negedge clk);
    checks++; if (o_locked !== 1'b1) begin failures++; $display("FAIL mon_15_cycles: got locked=%b required 1", o_locked); end
    @(negedge clk);
    checks++; if (o_locked !== 1'b0 || o_serdes_rst !== 1'b1 || o_relock_cnt !== 8'd1) begin
      failures++; $display("FAIL mon_trip: got locked=%b srst=%b cnt=%0d required 0/1/1", o_locked, o_serdes_rst, o_relock_cnt);
    end
    lane_word[3] = 4'b1100;
    n = 1;
    wait_until(0, 300, n, ok, hi, first, last);
    checks++; if (!ok || n != 74 || hi != 4) begin
      failures++; $display("FAIL mon_relock: got ok=%0d lock=%0d srst=%0d required 1/74/4", ok, n, hi);
    end
    checks++; if (o_relock_cnt !== 8'd1) begin failures++; $display("FAIL mon_cnt_sticky: got %0d required 1", o_relock_cnt); end
  endtask
`endif

  initial begin
    i_rst     = 1'b1;
    i_start   = 1'b0;
    i_dly_rdy = 1'b1;
    set_lanes(4'b1100, 4'b1100, 4'b1100, 4'b1100);
    clr_stats();
    test_reset();
    test_all_aligned();
    test_slip();
    test_fail();
    test_dly_rdy();
    test_rst_in_slip();
`ifdef SELECTIO_ALIGN_MONITOR_EN
    test_monitor();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
